// File: rtl/cordic_xy_serial.sv
// Bit-serial CORDIC X/Y rotation datapath: one shift-add/sub micro-rotation per W clocks, LSB first.
// Optional macro CORDIC_XY_OVF_EN adds a sticky signed-overflow flag output (ovf).
module cordic_xy_serial #(
  parameter int W    = 16,
  parameter int ITER = 16,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  x0,
  input  logic [W-1:0]  y0,
  input  logic          z_sign,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  x_out,
  output logic [W-1:0]  y_out,
  output logic [CW-1:0] iter_idx,
  output logic [CW-1:0] bit_idx,
  output logic [1:0]    dbg_state
`ifdef CORDIC_XY_OVF_EN
  ,
  output logic          ovf
`endif
);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle
  // pulse marking x_out/y_out valid; busy covers RUN and DONE.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [CW-1:0] B_LAST   = CW'(W - 1);
  localparam logic [CW-1:0] I_LAST   = CW'(ITER - 1);
  localparam logic [CW:0]   TAP_LAST = (CW + 1)'(W - 1);

  state_t         state_q;
  logic [W-1:0]   x_cur_q, y_cur_q, x_acc_q, y_acc_q;
  logic           cx_q, cy_q, d_q, done_q;
  logic [CW-1:0]  bit_q, iter_q;
`ifdef CORDIC_XY_OVF_EN
  logic           ovf_q;
`endif

  logic [CW:0]    tap_sum;
  logic [CW-1:0]  tap;
  logic           d, xs, ys, sub_x, sub_y, op_x, op_y;
  logic           cin_x, cin_y, sum_x, sum_y, cout_x, cout_y, xb, yb;

  always_comb begin
    tap_sum = {1'b0, bit_q} + {1'b0, iter_q};
    // Clamping the tap at the MSB replicates the sign bit: arithmetic shift.
    tap     = (tap_sum > TAP_LAST) ? B_LAST : tap_sum[CW-1:0];
    d       = (bit_q == '0) ? z_sign : d_q;
    xs      = x_cur_q[tap];
    ys      = y_cur_q[tap];
    xb      = x_cur_q[bit_q];
    yb      = y_cur_q[bit_q];
    sub_x   = ~d;
    sub_y   = d;
    op_x    = ys ^ sub_x;
    op_y    = xs ^ sub_y;
    cin_x   = (bit_q == '0) ? sub_x : cx_q;
    cin_y   = (bit_q == '0) ? sub_y : cy_q;
    sum_x   = xb ^ op_x ^ cin_x;
    sum_y   = yb ^ op_y ^ cin_y;
    cout_x  = (xb & op_x) | (cin_x & (xb ^ op_x));
    cout_y  = (yb & op_y) | (cin_y & (yb ^ op_y));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_cur_q <= '0;
      y_cur_q <= '0;
      x_acc_q <= '0;
      y_acc_q <= '0;
      cx_q    <= 1'b0;
      cy_q    <= 1'b0;
      d_q     <= 1'b0;
      done_q  <= 1'b0;
      bit_q   <= '0;
      iter_q  <= '0;
`ifdef CORDIC_XY_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_cur_q <= x0;
            y_cur_q <= y0;
            x_acc_q <= '0;
            y_acc_q <= '0;
            cx_q    <= 1'b0;
            cy_q    <= 1'b0;
            bit_q   <= '0;
            iter_q  <= '0;
`ifdef CORDIC_XY_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          d_q     <= d;
          cx_q    <= cout_x;
          cy_q    <= cout_y;
          x_acc_q <= {sum_x, x_acc_q[W-1:1]};
          y_acc_q <= {sum_y, y_acc_q[W-1:1]};
          if (bit_q == B_LAST) begin
            x_cur_q <= {sum_x, x_acc_q[W-1:1]};
            y_cur_q <= {sum_y, y_acc_q[W-1:1]};
`ifdef CORDIC_XY_OVF_EN
            ovf_q   <= ovf_q | (cin_x ^ cout_x) | (cin_y ^ cout_y);
`endif
            bit_q   <= '0;
            if (iter_q == I_LAST) begin
              iter_q  <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              iter_q <= iter_q + 1'b1;
            end
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign x_out     = x_cur_q;
  assign y_out     = y_cur_q;
  assign iter_idx  = iter_q;
  assign bit_idx   = bit_q;
  assign dbg_state = state_q;
`ifdef CORDIC_XY_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cordic_xy_serial.sv
// Randomized bench for cordic_xy_serial: three instances (ITER = 1, 2, 16) against a signed-arithmetic model.
module tb_cordic_xy_serial;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int NI = 3;

  logic          clk;
  logic          rst_n;
  logic          start_a  [NI];
  logic [W-1:0]  x0_a     [NI];
  logic [W-1:0]  y0_a     [NI];
  logic          zs_a     [NI];
  logic          busy_a   [NI];
  logic          done_a   [NI];
  logic [W-1:0]  xo_a     [NI];
  logic [W-1:0]  yo_a     [NI];
  logic [CW-1:0] it_a     [NI];
  logic [CW-1:0] bi_a     [NI];
  logic [1:0]    st_a     [NI];
`ifdef CORDIC_XY_OVF_EN
  logic          ovf_a    [NI];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int IT = (g == 0) ? 1 : (g == 1) ? 2 : 16;
    cordic_xy_serial #(.W(W), .ITER(IT), .CW(CW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_a[g]),
      .x0       (x0_a[g]),
      .y0       (y0_a[g]),
      .z_sign   (zs_a[g]),
      .busy     (busy_a[g]),
      .done     (done_a[g]),
      .x_out    (xo_a[g]),
      .y_out    (yo_a[g]),
      .iter_idx (it_a[g]),
      .bit_idx  (bi_a[g]),
      .dbg_state(st_a[g])
`ifdef CORDIC_XY_OVF_EN
      ,
      .ovf      (ovf_a[g])
`endif
    );
  end

  function automatic int iters(input int n);
    return (n == 0) ? 1 : (n == 1) ? 2 : 16;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain signed CORDIC rotation; overflow = signed result out of range.
  function automatic void model(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                input logic [15:0] dirs, input int it,
                                output logic [W-1:0] xr, output logic [W-1:0] yr,
                                output bit ov);
    logic signed [W-1:0] x, y, xs, ys;
    logic signed [W:0]   xn, yn;
    x  = xa;
    y  = ya;
    ov = 1'b0;
    for (int i = 0; i < it; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (!dirs[i]) begin
        xn = x - ys;
        yn = y + xs;
      end else begin
        xn = x + ys;
        yn = y - xs;
      end
      if (xn[W] != xn[W-1] || yn[W] != yn[W-1]) ov = 1'b1;
      x = xn[W-1:0];
      y = yn[W-1:0];
    end
    xr = x;
    yr = y;
  endfunction

  // ---------------- driver ----------------
  task automatic run_case(input int n, input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input logic [15:0] dirs, input bit hold, input bit tog);
    int           it;
    int           nc;
    logic [W-1:0] ex, ey;
    bit           eov;
    it = iters(n);
    nc = it * W;
    model(xa, ya, dirs, it, ex, ey, eov);
    exp_q.push_back(ex);
    exp_q.push_back(ey);
    @(negedge clk);
    check("idle_busy", {31'd0, busy_a[n]}, 32'd0);
    start_a[n] = 1'b1;
    x0_a[n]    = xa;
    y0_a[n]    = ya;
    zs_a[n]    = dirs[0];
    for (int c = 0; c < nc; c++) begin
      @(negedge clk);
      check("run_busy", {31'd0, busy_a[n]}, 32'd1);
      check("run_done", {31'd0, done_a[n]}, 32'd0);
      check("bit_idx",  {28'd0, bi_a[n]}, 32'(c % W));
      check("iter_idx", {28'd0, it_a[n]}, 32'(c / W));
      if (!hold) start_a[n] = 1'b0;
      x0_a[n] = W'($urandom);
      y0_a[n] = W'($urandom);
      if (c % W == 0) zs_a[n] = dirs[c / W];
      else            zs_a[n] = tog ? 1'($urandom) : dirs[c / W];
    end
    @(negedge clk);
    ex = exp_q.pop_front();
    ey = exp_q.pop_front();
    check("done_pulse", {31'd0, done_a[n]}, 32'd1);
    check("done_busy",  {31'd0, busy_a[n]}, 32'd1);
    check("x_out",      {16'd0, xo_a[n]}, {16'd0, ex});
    check("y_out",      {16'd0, yo_a[n]}, {16'd0, ey});
    check("done_idx",   {24'd0, it_a[n], bi_a[n]}, 32'd0);
`ifdef CORDIC_XY_OVF_EN
    check("ovf", {31'd0, ovf_a[n]}, {31'd0, eov});
`endif
    @(negedge clk);
    check("post_done",  {31'd0, done_a[n]}, 32'd0);
    check("post_busy",  {31'd0, busy_a[n]}, 32'd0);
    check("hold_x",     {16'd0, xo_a[n]}, {16'd0, ex});
    check("hold_y",     {16'd0, yo_a[n]}, {16'd0, ey});
    start_a[n] = 1'b0;
  endtask

  task automatic abort_case();
    @(negedge clk);
    start_a[2] = 1'b1;
    x0_a[2]    = 16'h1234;
    y0_a[2]    = 16'h4321;
    zs_a[2]    = 1'b0;
    for (int c = 0; c <= 5 * W + 7; c++) begin
      @(negedge clk);
      start_a[2] = 1'b0;
      zs_a[2]    = 1'($urandom);
    end
    check("abort_bit",  {28'd0, bi_a[2]}, 32'd7);
    check("abort_iter", {28'd0, it_a[2]}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_a[2]}, 32'd0);
    check("abort_x",    {16'd0, xo_a[2]}, 32'd0);
    check("abort_y",    {16'd0, yo_a[2]}, 32'd0);
    check("abort_idx",  {24'd0, it_a[2], bi_a[2]}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_nodone", {31'd0, done_a[2]}, 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_idle", {30'd0, busy_a[2], done_a[2]}, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int n = 0; n < NI; n++) begin
      start_a[n] = 1'b0;
      x0_a[n]    = '0;
      y0_a[n]    = '0;
      zs_a[n]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      check("rst_busy", {30'd0, busy_a[n], done_a[n]}, 32'd0);
      check("rst_xy",   {xo_a[n], yo_a[n]}, 32'd0);
      check("rst_idx",  {24'd0, it_a[n], bi_a[n]}, 32'd0);
`ifdef CORDIC_XY_OVF_EN
      check("rst_ovf",  {31'd0, ovf_a[n]}, 32'd0);
`endif
    end
    rst_n = 1'b1;

    run_case(0, 16'h1000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    run_case(1, 16'h1000, 16'h0800, 16'h0000, 1'b0, 1'b0);
    run_case(1, 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0);
    run_case(0, 16'h1000, 16'h0800, 16'h0001, 1'b0, 1'b1);
    run_case(2, 16'h2000, 16'h0000, 16'($urandom), 1'b1, 1'b1);
    run_case(2, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b1);

    for (int k = 0; k < 12; k++)
      run_case($urandom_range(0, NI - 1), 16'($urandom), 16'($urandom),
               16'($urandom), 1'($urandom), 1'b1);

    abort_case();
    run_case(2, 16'h0400, 16'hFC00, 16'($urandom), 1'b0, 1'b1);

`ifdef CORDIC_XY_OVF_EN
    run_case(0, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    run_case(0, 16'h1000, 16'h0800, 16'h0000, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
